// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between fetch (read-only) and data (read/write).
module mem_port_arbiter #(
    parameter int AW            = 14,
    parameter int DW            = 64,
    parameter int READ_LATENCY  = 1,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [DW-1:0]   dm_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            if_stall,
    output logic            dm_stall,
    output logic [31:0]     conflict_cnt
);
    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    logic [SW-1:0]           streak_q, streak_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d, own_q, own_d;
    logic [31:0]             conflict_q, conflict_d;
    logic                    fetch_first;
    assign fetch_first = streak_q == SW'(MAX_DM_STREAK);
    assign dm_gnt      = !reset && dm_req && !(if_req && fetch_first);
    assign if_gnt      = !reset && if_req && (!dm_req || fetch_first);
    assign if_stall    = !reset && if_req && !if_gnt;
    assign dm_stall    = !reset && dm_req && !dm_gnt;
    assign mem_en      = if_gnt || dm_gnt;
    assign mem_we      = dm_gnt && dm_we;
    assign mem_be      = (dm_gnt && dm_we) ? dm_be : '0;
    assign mem_addr    = dm_gnt ? dm_addr : (if_gnt ? if_addr : '0);
    assign mem_wdata   = dm_gnt ? dm_wdata : '0;
    // Tail of the in-flight pipe lines up with mem_rdata; own = 1 marks a data-side read.
    assign if_rvalid    = !reset && vld_q[READ_LATENCY-1] && !own_q[READ_LATENCY-1];
    assign dm_rvalid    = !reset && vld_q[READ_LATENCY-1] && own_q[READ_LATENCY-1];
    assign if_rdata     = mem_rdata;
    assign dm_rdata     = mem_rdata;
    assign conflict_cnt = conflict_q;
    always_comb begin
        streak_d   = (dm_gnt && if_req) ? streak_q + 1'b1 : '0;
        vld_d      = READ_LATENCY'({vld_q, if_gnt || (dm_gnt && !dm_we)});
        own_d      = READ_LATENCY'({own_q, dm_gnt});
        conflict_d = (if_req && dm_req && conflict_q != '1) ? conflict_q + 32'd1 : conflict_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q   <= '0;
            vld_q      <= '0;
            own_q      <= '0;
            conflict_q <= '0;
        end else begin
            streak_q   <= streak_d;
            vld_q      <= vld_d;
            own_q      <= own_d;
            conflict_q <= conflict_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of two arbiter instances (latency 1 and 3) sharing stimulus.
module tb_mem_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 64;
    logic clk = 1'b0;
    logic reset;
    logic if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [7:0] dm_be;
    logic [63:0] dm_wdata;
    logic a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_mem_en, a_mem_we, a_if_stall, a_dm_stall;
    logic b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_mem_en, b_mem_we, b_if_stall, b_dm_stall;
    logic [63:0] a_if_rdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;
    logic [63:0] b_if_rdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
    logic [7:0] a_mem_be, b_mem_be;
    logic [AW-1:0] a_mem_addr, b_mem_addr;
    logic [31:0] a_conflict_cnt, b_conflict_cnt;
    logic [63:0] mem [0:(1<<AW)-1];
    logic [63:0] ra, rb1, rb2, rb3;
    int n_chk = 0;
    int n_pass = 0;
    logic d, pd, ir, dr;
    int s;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .READ_LATENCY(1), .MAX_DM_STREAK(4)) u_a (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .if_stall(a_if_stall), .dm_stall(a_dm_stall), .conflict_cnt(a_conflict_cnt)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .READ_LATENCY(3), .MAX_DM_STREAK(4)) u_b (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .if_stall(b_if_stall), .dm_stall(b_dm_stall), .conflict_cnt(b_conflict_cnt)
    );

    // Memory: writes come from instance a; both instances issue identical accesses.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 64'hA000_0000_0000_0000 | 64'(i);
        end else if (a_mem_en && a_mem_we) begin
            for (int j = 0; j < 8; j++) if (a_mem_be[j]) mem[a_mem_addr][8*j +: 8] <= a_mem_wdata[8*j +: 8];
        end
        if (a_mem_en) ra <= mem[a_mem_addr];
        if (b_mem_en) rb1 <= mem[b_mem_addr];
        rb2 <= rb1;
        rb3 <= rb2;
    end
    assign a_mem_rdata = ra;
    assign b_mem_rdata = rb3;

    function automatic logic [63:0] initv(input int i);
        return 64'hA000_0000_0000_0000 | 64'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input int rs, input int ir_i, input int ia, input int dr_i, input int dw,
                         input int be, input int da, input logic [63:0] wd);
        @(negedge clk);
        reset    = rs != 0;
        if_req   = ir_i != 0;
        if_addr  = AW'(ia);
        dm_req   = dr_i != 0;
        dm_we    = dw != 0;
        dm_be    = 8'(be);
        dm_addr  = AW'(da);
        dm_wdata = wd;
        #1;
    endtask

    initial begin
        // reset with both requests high: everything forced low
        drive(1, 1, 9, 1, 0, 0, 9, 64'd0);
        chk("rst_if_gnt", 64'(a_if_gnt), 64'd0);
        chk("rst_dm_gnt", 64'(a_dm_gnt), 64'd0);
        chk("rst_if_stall", 64'(a_if_stall), 64'd0);
        chk("rst_dm_stall", 64'(a_dm_stall), 64'd0);
        chk("rst_mem_en", 64'(a_mem_en), 64'd0);
        drive(1, 1, 9, 1, 0, 0, 9, 64'd0);
        chk("rst_cnt", 64'(a_conflict_cnt), 64'd0);
        chk("rst_rvalid", 64'({a_if_rvalid, a_dm_rvalid, b_if_rvalid, b_dm_rvalid}), 64'd0);
        // fetch stream 0,1,2
        drive(0, 1, 0, 0, 0, 0, 0, 64'd0);
        chk("fs0_gnt", 64'(a_if_gnt), 64'd1);
        chk("fs0_addr", 64'(a_mem_addr), 64'd0);
        chk("fs0_we", 64'(a_mem_we), 64'd0);
        chk("fs0_rvalid", 64'(a_if_rvalid), 64'd0);
        for (int c = 1; c < 3; c++) begin
            drive(0, 1, c, 0, 0, 0, 0, 64'd0);
            chk("fs_gnt", 64'(a_if_gnt), 64'd1);
            chk("fs_addr", 64'(a_mem_addr), 64'(c));
            chk("fs_rvalid", 64'(a_if_rvalid), 64'd1);
            chk("fs_rdata", a_if_rdata, initv(c - 1));
            chk("fs_dm_rvalid", 64'(a_dm_rvalid), 64'd0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 64'd0);
        chk("fs3_gnt", 64'(a_if_gnt), 64'd0);
        chk("fs3_mem_en", 64'(a_mem_en), 64'd0);
        chk("fs3_rvalid", 64'(a_if_rvalid), 64'd1);
        chk("fs3_rdata", a_if_rdata, initv(2));
        chk("fs3_b_rvalid", 64'(b_if_rvalid), 64'd1);
        chk("fs3_b_rdata", b_if_rdata, initv(0));
        for (int c = 1; c < 3; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 64'd0);
            chk("fs_a_idle", 64'(a_if_rvalid), 64'd0);
            chk("fs_b_rvalid", 64'(b_if_rvalid), 64'd1);
            chk("fs_b_rdata", b_if_rdata, initv(c));
            chk("fs_b_dm", 64'(b_dm_rvalid), 64'd0);
        end
        // continuous conflict: fetch at addr 7, data read at addr 5
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 7, 1, 0, 0, 5, 64'd0);
            d = (k % 5) != 4;
            chk("cf_dm_gnt", 64'(a_dm_gnt), 64'(d));
            chk("cf_if_gnt", 64'(a_if_gnt), 64'(!d));
            chk("cf_b_dm_gnt", 64'(b_dm_gnt), 64'(d));
            chk("cf_if_stall", 64'(a_if_stall), 64'(d));
            chk("cf_addr", 64'(a_mem_addr), d ? 64'd5 : 64'd7);
            chk("cf_cnt", 64'(a_conflict_cnt), 64'(k));
            if (k >= 1) begin
                pd = ((k - 1) % 5) != 4;
                chk("cf_a_dm_rv", 64'(a_dm_rvalid), 64'(pd));
                chk("cf_a_if_rv", 64'(a_if_rvalid), 64'(!pd));
                chk("cf_a_rdata", pd ? a_dm_rdata : a_if_rdata, initv(pd ? 5 : 7));
            end else chk("cf_a_rv0", 64'({a_if_rvalid, a_dm_rvalid}), 64'd0);
            if (k >= 3) begin
                pd = ((k - 3) % 5) != 4;
                chk("cf_b_dm_rv", 64'(b_dm_rvalid), 64'(pd));
                chk("cf_b_if_rv", 64'(b_if_rvalid), 64'(!pd));
                chk("cf_b_rdata", pd ? b_dm_rdata : b_if_rdata, initv(pd ? 5 : 7));
            end else chk("cf_b_rv0", 64'({b_if_rvalid, b_dm_rvalid}), 64'd0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 64'd0);
            if (i == 0) begin
                chk("cf_cnt_end", 64'(a_conflict_cnt), 64'd10);
                chk("cf_a_last", 64'(a_if_rvalid), 64'd1);
            end
            chk("cf_b_dm_tail", 64'(b_dm_rvalid), 64'(i < 2));
            chk("cf_b_if_tail", 64'(b_if_rvalid), 64'(i == 2));
        end
        // alternating fetch/data reads at addresses 10..13
        for (int t = 0; t < 8; t++) begin
            ir = t < 4 && t % 2 == 0;
            dr = t < 4 && t % 2 == 1;
            drive(0, int'(ir), 10 + t, int'(dr), 0, 0, 10 + t, 64'd0);
            chk("alt_if_gnt", 64'(b_if_gnt), 64'(ir));
            chk("alt_dm_gnt", 64'(a_dm_gnt), 64'(dr));
            s = t - 1;
            chk("alt_a_if_rv", 64'(a_if_rvalid), 64'(s >= 0 && s < 4 && s % 2 == 0));
            chk("alt_a_dm_rv", 64'(a_dm_rvalid), 64'(s >= 0 && s < 4 && s % 2 == 1));
            if (s >= 0 && s < 4) chk("alt_a_rdata", a_mem_rdata, initv(10 + s));
            s = t - 3;
            chk("alt_b_if_rv", 64'(b_if_rvalid), 64'(s >= 0 && s < 4 && s % 2 == 0));
            chk("alt_b_dm_rv", 64'(b_dm_rvalid), 64'(s >= 0 && s < 4 && s % 2 == 1));
            if (s >= 0 && s < 4) chk("alt_b_rdata", (s % 2 == 0) ? b_if_rdata : b_dm_rdata, initv(10 + s));
        end
        // partial write then read back
        drive(0, 0, 0, 1, 1, 8'h0F, 3, 64'h1122334455667788);
        chk("wr_gnt", 64'(a_dm_gnt), 64'd1);
        chk("wr_we", 64'(a_mem_we), 64'd1);
        chk("wr_be", 64'(a_mem_be), 64'h0F);
        chk("wr_addr", 64'(a_mem_addr), 64'd3);
        chk("wr_wdata", a_mem_wdata, 64'h1122334455667788);
        chk("wr_b_we_be", 64'({b_mem_we, b_mem_be}), 64'h10F);
        chk("wr_b_wdata", b_mem_wdata, 64'h1122334455667788);
        drive(0, 0, 0, 1, 0, 8'h0F, 3, 64'd0);
        chk("rd_be", 64'(a_mem_be), 64'd0);
        chk("rd_we", 64'(a_mem_we), 64'd0);
        chk("wr_no_rvalid", 64'(a_dm_rvalid), 64'd0);
        drive(0, 0, 0, 1, 1, 8'hFF, 4, 64'hDEAD_BEEF_0000_0001);
        chk("wr2_we", 64'(a_mem_we), 64'd1);
        chk("rd_rvalid", 64'(a_dm_rvalid), 64'd1);
        chk("rd_rdata", a_dm_rdata, 64'hA000_0000_5566_7788);
        chk("rd_if_rv", 64'(a_if_rvalid), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 64'd0);
        chk("wr2_no_rvalid", 64'(a_dm_rvalid), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 64'd0);
        chk("rd_b_rvalid", 64'(b_dm_rvalid), 64'd1);
        chk("rd_b_rdata", b_dm_rdata, 64'hA000_0000_5566_7788);
        drive(0, 0, 0, 0, 0, 0, 0, 64'd0);
        // reset with reads in flight and a partial data streak
        drive(0, 1, 6, 1, 0, 0, 6, 64'd0);
        chk("rf_gnt0", 64'(a_dm_gnt), 64'd1);
        drive(0, 1, 6, 1, 0, 0, 6, 64'd0);
        chk("rf_gnt1", 64'(a_dm_gnt), 64'd1);
        drive(1, 1, 6, 1, 0, 0, 6, 64'd0);
        chk("rf_gnts", 64'({a_if_gnt, a_dm_gnt, b_if_gnt, b_dm_gnt}), 64'd0);
        chk("rf_stalls", 64'({a_if_stall, a_dm_stall, b_if_stall, b_dm_stall}), 64'd0);
        chk("rf_mem_en", 64'(a_mem_en), 64'd0);
        chk("rf_a_rvalid", 64'(a_dm_rvalid), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 64'd0);
        chk("rf_cnt", 64'(a_conflict_cnt), 64'd0);
        chk("rf_mem_en2", 64'(a_mem_en), 64'd0);
        chk("rf_rvalid", 64'({a_dm_rvalid, b_dm_rvalid}), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 64'd0);
        chk("rf_b_rvalid", 64'(b_dm_rvalid), 64'd0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 6, 1, 0, 0, 6, 64'd0);
            chk("rf_streak_dm", 64'(a_dm_gnt), 64'(k < 4));
            chk("rf_streak_if", 64'(a_if_gnt), 64'(k == 4));
        end
        // saturation of conflict_cnt
        drive(0, 0, 0, 0, 0, 0, 0, 64'd0);
        force u_a.conflict_q = 32'hFFFF_FFFD;
        force u_b.conflict_q = 32'hFFFF_FFFD;
        #1;
        release u_a.conflict_q;
        release u_b.conflict_q;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 1, 0, 0, 0, 64'd0);
            chk("sat_cnt", 64'(a_conflict_cnt), (k < 3) ? 64'(32'hFFFF_FFFD + 32'(k)) : 64'hFFFF_FFFF);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 64'd0);
        chk("sat_hold", 64'(a_conflict_cnt), 64'hFFFF_FFFF);
        chk("sat_hold_b", 64'(b_conflict_cnt), 64'hFFFF_FFFF);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the fetch stage (read-only) and the memory stage (read/write). The fetch and data paths can then share one memory macro instead of two.
- Grants are combinational, issue is one per cycle, and the pipeline can be kept full.
- Read responses are steered back to the requester that issued them after a fixed memory latency.
- Data has priority over fetch, with a bounded-starvation guarantee for fetch, and stall outputs feed the hazard unit.

Parameters:
- AW, 14: word address width.
- DW, 64: data width; byte-enable width is DW/8.
- READ_LATENCY, 1: cycles from mem_en to valid mem_rdata; must be 1 to 4.
- MAX_DM_STREAK, 4: consecutive data grants allowed while fetch waits, before fetch is forced through.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request.
- if_addr  in  AW  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  DW  fetch read data.
- dm_req  in  1  data request.
- dm_we  in  1  1 = write, 0 = read.
- dm_be  in  DW/8  write byte enables.
- dm_addr  in  AW  data word address.
- dm_wdata  in  DW  write data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  dm_rdata valid (reads only).
- dm_rdata  out  DW  data read data.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write.
- mem_be  out  DW/8  memory byte enables; all zero on reads.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid READ_LATENCY cycles after mem_en.
- if_stall  out  1  if_req and not if_gnt.
- dm_stall  out  1  dm_req and not dm_gnt.
- conflict_cnt  out  32  cycles in which both requests were high.

Behaviour:

Grant logic (combinational, same cycle)
- Only dm_req high: data is granted.
- Only if_req high: fetch is granted.
- Both high: data wins unless streak == MAX_DM_STREAK, in which case fetch wins.
- At most one grant per cycle. There is no backpressure from memory.
- mem_en = if_gnt or dm_gnt. mem_* are driven from the winner.
- On a fetch grant: mem_we = 0, mem_be = 0.
- On no grant: mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.

Streak counter (register, width clog2(MAX_DM_STREAK+1))
- Data grant while if_req is high: streak increments.
- Fetch grant, or if_req low: streak is cleared to 0.
- Consequence: fetch waits at most MAX_DM_STREAK cycles.

Response tracking
- A shift register of depth READ_LATENCY holds {valid, owner} per entry.
- A grant pushes valid = (read), owner = if or dm. Data writes push valid = 0.
- The tail entry drives the responses:
  - if_rvalid = tail valid and owner = if.
  - dm_rvalid = tail valid and owner = dm.
- if_rdata and dm_rdata both equal mem_rdata, unregistered; only rvalid qualifies them.
- Latency is exactly READ_LATENCY cycles from the grant cycle to rvalid.
- Back-to-back grants produce back-to-back responses, in order.

Requester rules
- A requester keeps req and its payload stable until granted.
- The arbiter never drops an ungranted request; it is re-arbitrated each cycle.

Stall outputs
- if_stall and dm_stall are combinational.

conflict_cnt
- Increments each cycle in which if_req and dm_req are both high.
- Saturates at 32'hFFFF_FFFF.

Reset (synchronous)
- Clears the shift register, streak and conflict_cnt.
- While reset is high, all gnt, rvalid, stall and mem_en are forced to 0.
- Reads in flight when reset asserts never produce rvalid.

Simultaneous write and read-response
- A data write granted in the same cycle that a read response returns is legal; the response is unaffected.

Test Plan:
- Only if_req, addresses 0,1,2 on consecutive cycles, READ_LATENCY=1 -> if_gnt high 3 cycles; if_rvalid high in cycles 1..3 with mem contents of 0,1,2; dm_rvalid stays 0.
- if_req and dm_req (read, addr 5) both high continuously, MAX_DM_STREAK=4 -> grant pattern dm,dm,dm,dm,if repeating; if_stall high 4 of 5 cycles; conflict_cnt increments every cycle.
- dm write (addr 3, be=8'h0F, wdata=64'h1122334455667788), then dm read addr 3 -> mem_we=1 with be=0F on the write; the read returns the low 4 bytes updated; no dm_rvalid for the write.
- READ_LATENCY=3, alternating if/dm read grants -> each rvalid arrives exactly 3 cycles after its grant, routed to the correct owner, no cross-talk.
- Reset asserted one cycle after a read grant with READ_LATENCY=2 -> no rvalid produced; streak, conflict_cnt and mem_en are 0 the cycle after reset.
- conflict_cnt preloaded near saturation via forced conflict cycles -> holds at 32'hFFFF_FFFF without wrap.
